mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 26 ++
 rtl/mem_ctrl_lane_align.sv | 54 +++++
 rtl/mem_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller slice.
//   state_t      : controller FSM states
//   SZ_*         : request size codes (1, 2, 4, 8 bytes)
//   ADDR_BITS_DEFAULT : implemented byte-address bits of the attached RAM (256 MB)
//   DATA_W       : RAM data bus width
package mem_ctrl_pkg;

  localparam int DATA_W            = 64;
  localparam int ADDR_BITS_DEFAULT = 28;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_D  = 3'd2,
    RMW_A = 3'd3,
    RMW_D = 3'd4,
    WR    = 3'd5,
    ERR   = 3'd6
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

endpackage

// File: rtl/mem_ctrl_lane_align.sv
// mem_lane_align: combinational byte-lane handling for a big-endian 64-bit RAM
// word whose most significant byte sits at the access address.
//   size       in  2  : access size code (SZ_B/SZ_H/SZ_W/SZ_D)
//   is_signed  in  1  : sign-extend the extracted load field
//   doubleword in  64 : word read from the RAM
//   wdata      in  64 : store data, right-aligned
//   rdata      out 64 : top 8n bits of doubleword, right-aligned and extended
//   merged     out 64 : doubleword with its top 8n bits replaced by wdata[8n-1:0]
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] doubleword,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] merged
);

  // Bit distance from the low edge of the accessed field down to bit 0.
  function automatic logic [6:0] lane_shift(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 7'd56;
      SZ_H:    return 7'd48;
      SZ_W:    return 7'd32;
      default: return 7'd0;
    endcase
  endfunction

  // Arithmetic shift brings the field down with sign fill; logical shift zero-fills.
  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] dw,
                                                input logic [6:0]        sh,
                                                input logic              sx);
    logic signed [DATA_W-1:0] dw_s;
    dw_s = $signed(dw);
    if (sx) return dw_s >>> sh;
    return dw >> sh;
  endfunction

  // Low sh bits are the untouched bytes; a full doubleword (sh = 0) keeps nothing.
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] dw,
                                              input logic [DATA_W-1:0] wd,
                                              input logic [6:0]        sh);
    logic [DATA_W-1:0] keep;
    keep = {DATA_W{1'b1}} >> (7'd64 - sh);
    return (dw & keep) | (wd << sh);
  endfunction

  always_comb begin
    rdata  = extract(doubleword, lane_shift(size), is_signed);
    merged = merge(doubleword, wdata, lane_shift(size));
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-request load/store controller for an asynchronous 64-bit
// big-endian RAM. Sub-doubleword stores use read-modify-write.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready      : request handshake (ready only in IDLE)
//   req_we, req_size, req_signed, req_addr, req_wdata : request fields
//   resp_valid, resp_rdata, resp_err : one-cycle completion pulse and result
//   mem_cs, mem_we, mem_oe   : active-low RAM strobes
//   mem_addr, mem_data       : RAM address and bidirectional data bus
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_cs,
  output logic        mem_we,
  output logic        mem_oe,
  output logic [63:0] mem_addr,
  inout  wire  [63:0] mem_data
);

  // Highest address whose 8-byte window still lies inside the RAM.
  localparam logic [63:0] ADDR_LIMIT = (64'd1 << ADDR_BITS) - 64'd8;

  state_t            state_q;
  state_t            state_d;
  logic              accept;
  logic              addr_bad;

  logic [1:0]        size_p0;
  logic              signed_p0;
  logic [63:0]       addr_p0;
  logic [63:0]       wdata_p0;
  logic [63:0]       dw_p1;
  logic              vld_p1;
  logic              err_p1;
  logic              rd_p1;

  logic [63:0]       lane_rdata;
  logic [63:0]       lane_merged;

  assign accept   = (state_q == IDLE) && req_valid;
  assign addr_bad = (req_addr > ADDR_LIMIT);

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_cs    = 1'b1;
    mem_we    = 1'b1;
    mem_oe    = 1'b1;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (addr_bad)              state_d = ERR;
          else if (!req_we)          state_d = RD_A;
          else if (req_size == SZ_D) state_d = WR;
          else                       state_d = RMW_A;
        end
      end
      RD_A: begin
        mem_cs  = 1'b0;
        mem_oe  = 1'b0;
        state_d = RD_D;
      end
      RD_D: begin
        mem_cs  = 1'b0;
        mem_oe  = 1'b0;
        state_d = IDLE;
      end
      RMW_A: begin
        mem_cs  = 1'b0;
        mem_oe  = 1'b0;
        state_d = RMW_D;
      end
      RMW_D: begin
        mem_cs  = 1'b0;
        mem_oe  = 1'b0;
        state_d = WR;
      end
      WR: begin
        mem_cs  = 1'b0;
        mem_we  = 1'b0;
        state_d = IDLE;
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage 0: state register and request latch at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_p0 <= '0;
    end else begin
      state_q <= state_d;
      if (accept) addr_p0 <= req_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      size_p0   <= req_size;
      signed_p0 <= req_signed;
      wdata_p0  <= req_wdata;
    end
  end

  // Stage 1: RAM word capture and completion flags for the IDLE re-entry cycle.
  always_ff @(posedge clk) begin
    if (state_q == RD_D || state_q == RMW_D) dw_p1 <= mem_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
      rd_p1  <= 1'b0;
    end else begin
      vld_p1 <= (state_q == RD_D) || (state_q == WR) || (state_q == ERR);
      err_p1 <= (state_q == ERR);
      rd_p1  <= (state_q == RD_D);
    end
  end

  mem_lane_align u_lane (
    .size       (size_p0),
    .is_signed  (signed_p0),
    .doubleword (dw_p1),
    .wdata      (wdata_p0),
    .rdata      (lane_rdata),
    .merged     (lane_merged)
  );

  assign resp_valid = vld_p1;
  assign resp_err   = vld_p1 && err_p1;
  assign resp_rdata = (vld_p1 && rd_p1) ? lane_rdata : 64'd0;
  assign mem_addr   = addr_p0;
  assign mem_data   = (state_q == WR) ? lane_merged : {64{1'bz}};

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic        mem_cs, mem_we, mem_oe;
  logic [63:0] mem_addr;
  wire  [63:0] mem_data;

  mem_ctrl #(.ADDR_BITS(28)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_addr(mem_addr), .mem_data(mem_data)
  );

  // RAM: 4 KB window, big-endian 8-byte word starting at mem_addr.
  logic [7:0]  ram [0:4095];
  logic        ram_clr;
  logic [63:0] rd_word;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 8; i++) rd_word[63-8*i -: 8] = ram[mem_addr[11:0] + 12'(i)];
  end
  assign mem_data = (!mem_cs && !mem_oe) ? rd_word : {64{1'bz}};

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
    end else if (!mem_cs && !mem_we) begin
      for (int i = 0; i < 8; i++) ram[mem_addr[11:0] + 12'(i)] <= mem_data[63-8*i -: 8];
    end
  end

  int conflicts = 0;
  int xcount    = 0;
  always @(negedge clk) begin
    if (!mem_we && !mem_oe) conflicts <= conflicts + 1;
    if (!mem_cs && $isunknown(mem_data)) xcount <= xcount + 1;
  end

  // Reference model: flat byte array, requests computed from size/endianness rules.
  logic [7:0] mdl [0:4095];

  function automatic logic [11:0] ix(input logic [63:0] a, input int k);
    return a[11:0] + 12'(k);
  endfunction

  function automatic logic mdl_err(input logic [63:0] a);
    return a > ((64'd1 << 28) - 64'd8);
  endfunction

  function automatic logic [63:0] mdl_load(input logic [63:0] a, input logic [1:0] sz, input logic sg);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = '0;
    for (int k = 0; k < n; k++) v = (v << 8) | 64'(mdl[ix(a, k)]);
    if (sg && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
    return v;
  endfunction

  task automatic mdl_store(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] wd);
    int n;
    n = 1 << sz;
    for (int k = 0; k < n; k++) mdl[ix(a, k)] = wd[8*(n-1-k) +: 8];
  endtask

  function automatic int mdl_lat(input logic we, input logic [1:0] sz, input logic er);
    if (er) return 2;
    if (!we) return 3;
    if (sz == SZ_D) return 2;
    return 4;
  endfunction

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Issue one request from a negedge; returns at the negedge of the response cycle.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [63:0] addr, input logic [63:0] wd,
                        output logic [63:0] rd, output logic er, output int lat,
                        output int wr_cyc, output int cs_cyc, output int addr_bad);
    int guard;
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    // Scramble request fields: the controller must work from its latched copy.
    req_valid = 1'b0; req_we = ~we; req_size = ~sz; req_signed = ~sg;
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    rd = '0; er = 1'b0; lat = 0; wr_cyc = 0; cs_cyc = 0; addr_bad = 0;
    while (lat < 12) begin
      @(negedge clk);
      lat++;
      if (!mem_we) wr_cyc++;
      if (!mem_cs) begin
        cs_cyc++;
        if (mem_addr !== addr) addr_bad++;
      end
      if (resp_valid) begin
        rd = resp_rdata;
        er = resp_err;
        break;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [63:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  vec_t vt [18];

  logic [63:0] rd;
  logic        er;
  int          lat, wr_cyc, cs_cyc, abad;

  initial begin
    rst = 1'b1; ram_clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 4096; i++) mdl[i] = 8'h00;

    vt[0]  = '{1'b1, SZ_D, 1'b0, 64'h100,       64'h1122334455667788, 64'h0,                1'b0, 2, 1};
    vt[1]  = '{1'b0, SZ_D, 1'b0, 64'h100,       64'h0, 64'h1122334455667788,                1'b0, 3, 0};
    vt[2]  = '{1'b0, SZ_B, 1'b1, 64'h107,       64'h0, 64'hFFFFFFFFFFFFFF88,                1'b0, 3, 0};
    vt[3]  = '{1'b0, SZ_B, 1'b0, 64'h107,       64'h0, 64'h0000000000000088,                1'b0, 3, 0};
    vt[4]  = '{1'b1, SZ_H, 1'b0, 64'h102,       64'h000000000000ABCD, 64'h0,                1'b0, 4, 1};
    vt[5]  = '{1'b0, SZ_D, 1'b0, 64'h100,       64'h0, 64'h1122ABCD55667788,                1'b0, 3, 0};
    vt[6]  = '{1'b0, SZ_D, 1'b0, 64'h0FFFFFF9,  64'h0, 64'h0,                               1'b1, 2, 0};
    vt[7]  = '{1'b1, SZ_W, 1'b0, 64'h100000000, 64'h12345678, 64'h0,                        1'b1, 2, 0};
    vt[8]  = '{1'b0, SZ_H, 1'b1, 64'h102,       64'h0, 64'hFFFFFFFFFFFFABCD,                1'b0, 3, 0};
    vt[9]  = '{1'b0, SZ_W, 1'b0, 64'h104,       64'h0, 64'h0000000055667788,                1'b0, 3, 0};
    vt[10] = '{1'b1, SZ_W, 1'b0, 64'h104,       64'hDEADBEEFCAFEF00D, 64'h0,                1'b0, 4, 1};
    vt[11] = '{1'b0, SZ_D, 1'b0, 64'h100,       64'h0, 64'h1122ABCDCAFEF00D,                1'b0, 3, 0};
    vt[12] = '{1'b0, SZ_W, 1'b1, 64'h104,       64'h0, 64'hFFFFFFFFCAFEF00D,                1'b0, 3, 0};
    vt[13] = '{1'b0, SZ_D, 1'b1, 64'h100,       64'h0, 64'h1122ABCDCAFEF00D,                1'b0, 3, 0};
    vt[14] = '{1'b0, SZ_D, 1'b0, 64'h0FFFFFF8,  64'h0, 64'h0,                               1'b0, 3, 0};
    vt[15] = '{1'b1, SZ_B, 1'b0, 64'h0FFFFFF9,  64'h55, 64'h0,                              1'b1, 2, 0};
    vt[16] = '{1'b1, SZ_B, 1'b0, 64'h101,       64'h12345678000000EE, 64'h0,                1'b0, 4, 1};
    vt[17] = '{1'b0, SZ_D, 1'b0, 64'h100,       64'h0, 64'h11EEABCDCAFEF00D,                1'b0, 3, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready",  64'(req_ready),  64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err",   64'(resp_err),   64'd0);
    chk("rst_resp_rdata", resp_rdata,      64'd0);
    chk("rst_mem_cs",     64'(mem_cs),     64'd1);
    chk("rst_mem_we",     64'(mem_we),     64'd1);
    chk("rst_mem_oe",     64'(mem_oe),     64'd1);
    chk("rst_mem_addr",   mem_addr,        64'd0);
    rst = 1'b0; ram_clr = 1'b0;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 18; i++) begin
      do_req(vt[i].we, vt[i].sz, vt[i].sg, vt[i].addr, vt[i].wd, rd, er, lat, wr_cyc, cs_cyc, abad);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 64'(er), 64'(vt[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].exp_lat));
      chk($sformatf("vec%0d_wr_cycles", i), 64'(wr_cyc), 64'(vt[i].exp_wr));
      chk($sformatf("vec%0d_mem_addr", i), 64'(abad), 64'd0);
      if (vt[i].exp_err) chk($sformatf("vec%0d_cs_idle", i), 64'(cs_cyc), 64'd0);
      if (vt[i].we && !vt[i].exp_err) mdl_store(vt[i].addr, vt[i].sz, vt[i].wd);
      @(negedge clk);
      chk($sformatf("vec%0d_pulse_len", i), 64'(resp_valid), 64'd0);
    end

    // Reset during RMW_D of a byte store to 0x100
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_B; req_signed = 1'b0;
    req_addr = 64'h100; req_wdata = 64'h5A;
    chk("rmw_rst_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_a_oe", 64'({mem_cs, mem_oe, mem_we}), 64'b001);
    @(negedge clk);
    chk("rmw_d_oe", 64'({mem_cs, mem_oe, mem_we}), 64'b001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rmw_rst_idle",  64'(req_ready),  64'd1);
    chk("rmw_rst_resp",  64'(resp_valid), 64'd0);
    chk("rmw_rst_cs",    64'(mem_cs),     64'd1);
    begin
      int pulses;
      pulses = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (resp_valid || !mem_cs) pulses++;
      end
      chk("rmw_rst_no_replay", 64'(pulses), 64'd0);
    end
    chk("rmw_rst_ram_byte", 64'(ram[12'h100]), 64'h11);
    do_req(1'b0, SZ_B, 1'b0, 64'h100, 64'h0, rd, er, lat, wr_cyc, cs_cyc, abad);
    chk("rmw_rst_reload", rd, 64'h11);
    @(negedge clk);

    // Back-to-back loads with req_valid held high
    begin
      int acc, resps;
      acc = 0; resps = 0;
      req_valid = 1'b1; req_we = 1'b0; req_size = SZ_D; req_signed = 1'b0;
      req_addr = 64'h100; req_wdata = '0;
      for (int c = 0; c < 30; c++) begin
        if (req_valid && req_ready) acc++;
        if (resp_valid) begin
          resps++;
          chk($sformatf("b2b_rdata%0d", resps), resp_rdata, 64'h11EEABCDCAFEF00D);
          chk($sformatf("b2b_ready%0d", resps), 64'(req_ready), 64'd1);
        end
        @(negedge clk);
      end
      req_valid = 1'b0;
      chk("b2b_accepts", 64'(acc), 64'd10);
      chk("b2b_responses", 64'(resps), 64'd9);
      repeat (4) @(negedge clk);
    end

    // Randomized traffic against the byte-array model
    for (int t = 0; t < 300; t++) begin
      logic        we, sg, exp_er;
      logic [1:0]  sz;
      logic [63:0] addr, wd, exp_rd;
      we = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      wd = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0:       addr = (64'd1 << 28) - 64'd8 + 64'($urandom_range(1, 64));
        1:       addr = {32'($urandom_range(1, 255)), 32'($urandom)};
        default: addr = 64'($urandom_range(0, 32'hFF8));
      endcase
      exp_er = mdl_err(addr);
      exp_rd = (we || exp_er) ? 64'd0 : mdl_load(addr, sz, sg);
      do_req(we, sz, sg, addr, wd, rd, er, lat, wr_cyc, cs_cyc, abad);
      chk($sformatf("rnd%0d_rdata", t), rd, exp_rd);
      chk($sformatf("rnd%0d_err", t), 64'(er), 64'(exp_er));
      chk($sformatf("rnd%0d_latency", t), 64'(lat), 64'(mdl_lat(we, sz, exp_er)));
      if (we && !exp_er) mdl_store(addr, sz, wd);
      @(negedge clk);
    end

    chk("bus_contention", 64'(conflicts), 64'd0);
    chk("bus_unknown", 64'(xcount), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
